// File: rtl/shift_unit_pipe_pkg.sv
// Shared types for the pipelined shift unit: function encoding and mask sizing.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_ROL = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_func_t;

    localparam int SHIFT_N_DEFAULT = 32;

    // A thermometer over an amount field of log_n bits needs one bit per possible amount.
    function automatic int therm_width(input int log_n);
        return 32'sd1 << log_n;
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Elastic request/response bundle between the execute stage and the shift unit.
interface shift_unit_pipe_if
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N_DEFAULT
);
    localparam int LOG_N = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [LOG_N-1:0] sa;
    shift_func_t      func;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     z;

    modport master (
        output in_valid, a, sa, func, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, a, sa, func, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/shift_unit_pipe_cls_rotator.sv
// Combinational cyclic-left rotator: LOG_N cascaded 2:1 stages, stage i rotates by 2**i.
module cls_rotator #(
    parameter int N = 32
) (
    input  logic [N-1:0]         din,
    input  logic [$clog2(N)-1:0] rot_amt,
    output logic [N-1:0]         dout
);
    localparam int LOG_N = $clog2(N);

    for (genvar i = 0; i < LOG_N; i++) begin : g_stage
        localparam int SH = 1 << i;
        logic [N-1:0] in_s;
        logic [N-1:0] out_s;

        if (i == 0) begin : g_first
            assign in_s = din;
        end else begin : g_next
            assign in_s = g_stage[i-1].out_s;
        end

        assign out_s = rot_amt[i] ? {in_s[N-1-SH:0], in_s[N-1:N-SH]} : in_s;
    end

    assign dout = g_stage[LOG_N-1].out_s;
endmodule

// File: rtl/shift_unit_pipe.sv
// Three-stage MIPS shift unit (capture, rotate, mask/fill) with a stallable valid/ready pipe.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    shift_unit_pipe_if.slave   bus
);
    localparam int LOG_N  = $clog2(N);
    localparam int MASK_W = therm_width(LOG_N);

    // Stage valid bits and payload registers.
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [N-1:0]     a1_q, a1_d;
    shift_func_t      f1_q, f1_d;
    logic [LOG_N-1:0] sa1_q, sa1_d;
    logic [N-1:0]     r2_q, r2_d;
    shift_func_t      f2_q, f2_d;
    logic [LOG_N-1:0] sa2_q, sa2_d;
    logic             sign2_q, sign2_d;
    logic [N-1:0]     z_q, z_d;

    logic             adv1_s, adv2_s, adv3_s;
    logic             en1_s, en2_s, en3_s;
    logic [LOG_N-1:0] rot_amt_s;
    logic [N-1:0]     rot_s;
    logic [MASK_W-1:0] low_mask_s, high_mask_s;
    logic [N-1:0]     fix_z_s;

    // Stage k may load when it is empty or its contents move on this cycle.
    always_comb begin
        adv3_s = v3_q & bus.out_ready;
        en3_s  = ~v3_q | adv3_s;
        adv2_s = v2_q & en3_s;
        en2_s  = ~v2_q | adv2_s;
        adv1_s = v1_q & en2_s;
        en1_s  = ~v1_q | adv1_s;
    end

    // Right shifts become left rotations by (N - sa) mod N; the LOG_N-bit negate wraps sa=0 to 0.
    always_comb begin
        rot_amt_s = sa1_q;
        if (f1_q == SH_SRL || f1_q == SH_SRA) begin
            rot_amt_s = {LOG_N{1'b0}} - sa1_q;
        end else begin
            rot_amt_s = sa1_q;
        end
    end

    cls_rotator #(.N(N)) u_rot (
        .din     (a1_q),
        .rot_amt (rot_amt_s),
        .dout    (rot_s)
    );

    // Thermometer of sa gives the low-bit mask; its bit reversal covers the top sa bits.
    always_comb begin
        low_mask_s  = {MASK_W{1'b0}};
        high_mask_s = {MASK_W{1'b0}};
        for (int i = 0; i < MASK_W; i++) begin
            low_mask_s[i] = (i < int'(sa2_q));
        end
        for (int i = 0; i < MASK_W; i++) begin
            high_mask_s[MASK_W-1-i] = low_mask_s[i];
        end
    end

    // Fix-up: clear the wrapped-in bits, or fill them with the sign for SRA.
    always_comb begin
        fix_z_s = r2_q;
        case (f2_q)
            SH_SLL:  fix_z_s = r2_q & ~low_mask_s;
            SH_ROL:  fix_z_s = r2_q;
            SH_SRL:  fix_z_s = r2_q & ~high_mask_s;
            SH_SRA:  fix_z_s = (r2_q & ~high_mask_s) | ({N{sign2_q}} & high_mask_s);
            default: fix_z_s = r2_q;
        endcase
    end

    // Next state: payloads only load alongside a valid op so z holds across bubbles.
    always_comb begin
        v1_d    = v1_q;
        a1_d    = a1_q;
        f1_d    = f1_q;
        sa1_d   = sa1_q;
        v2_d    = v2_q;
        r2_d    = r2_q;
        f2_d    = f2_q;
        sa2_d   = sa2_q;
        sign2_d = sign2_q;
        v3_d    = v3_q;
        z_d     = z_q;

        if (en1_s) begin
            v1_d = bus.in_valid;
        end else begin
            v1_d = v1_q;
        end
        if (en1_s && bus.in_valid) begin
            a1_d  = bus.a;
            f1_d  = bus.func;
            sa1_d = bus.sa;
        end else begin
            a1_d  = a1_q;
        end

        if (en2_s) begin
            v2_d = v1_q;
        end else begin
            v2_d = v2_q;
        end
        if (en2_s && v1_q) begin
            r2_d    = rot_s;
            f2_d    = f1_q;
            sa2_d   = sa1_q;
            sign2_d = a1_q[N-1];
        end else begin
            r2_d    = r2_q;
        end

        if (en3_s) begin
            v3_d = v2_q;
        end else begin
            v3_d = v3_q;
        end
        if (en3_s && v2_q) begin
            z_d = fix_z_s;
        end else begin
            z_d = z_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            a1_q    <= {N{1'b0}};
            f1_q    <= SH_SLL;
            sa1_q   <= {LOG_N{1'b0}};
            v2_q    <= 1'b0;
            r2_q    <= {N{1'b0}};
            f2_q    <= SH_SLL;
            sa2_q   <= {LOG_N{1'b0}};
            sign2_q <= 1'b0;
            v3_q    <= 1'b0;
            z_q     <= {N{1'b0}};
        end else begin
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            f1_q    <= f1_d;
            sa1_q   <= sa1_d;
            v2_q    <= v2_d;
            r2_q    <= r2_d;
            f2_q    <= f2_d;
            sa2_q   <= sa2_d;
            sign2_q <= sign2_d;
            v3_q    <= v3_d;
            z_q     <= z_d;
        end
    end

    assign bus.in_ready  = en1_s;
    assign bus.out_valid = v3_q;
    assign bus.z         = z_q;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: arithmetic reference model, scoreboard queue, stall/reset scenarios.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_unit_pipe_if #(.N(32)) bus ();

    shift_unit_pipe #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  s;
        logic [1:0]  f;
        logic [31:0] exp;
    } op_t;

    // Hand-computed expectations; f: 0 SLL, 1 ROL, 2 SRL, 3 SRA.
    op_t vec [0:11] = '{
        {32'h800000F0, 5'd4,  2'd3, 32'hF800000F},
        {32'h800000F0, 5'd4,  2'd2, 32'h0800000F},
        {32'h800000F0, 5'd4,  2'd1, 32'h00000F08},
        {32'hDEADBEEF, 5'd0,  2'd0, 32'hDEADBEEF},
        {32'hDEADBEEF, 5'd0,  2'd1, 32'hDEADBEEF},
        {32'hDEADBEEF, 5'd0,  2'd2, 32'hDEADBEEF},
        {32'hDEADBEEF, 5'd0,  2'd3, 32'hDEADBEEF},
        {32'h80000000, 5'd31, 2'd3, 32'hFFFFFFFF},
        {32'h12345678, 5'd31, 2'd0, 32'h00000000},
        {32'hFFFFFFFF, 5'd31, 2'd2, 32'h00000001},
        {32'h80000000, 5'd1,  2'd1, 32'h00000001},
        {32'h7FFFFFFF, 5'd16, 2'd3, 32'h00007FFF}
    };

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] exp_q [$];
    int          out_cycles [$];

    function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic [1:0] f);
        case (f)
            2'd0:    return a << s;
            2'd1:    return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            2'd2:    return a >> s;
            default: return 32'($signed(a) >>> s);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every cycle with out_valid the front of the queue must be on z.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (reset === 1'b1) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", 32'd1, 32'd0);
                    end else begin
                        chk("z_vs_model", bus.z, exp_q[0]);
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            out_cycles.push_back(cycle);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.a, int'(bus.sa), bus.func));
                end
            end
        end
    end

    task automatic send(input op_t op, output int waited);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a        = op.a;
        bus.sa       = op.s;
        bus.func     = shift_func_t'(op.f);
        @(negedge clk);
        while (!bus.in_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("accept_bound", (n < 64) ? 32'd1 : 32'd0, 32'd1);
        waited = n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] zsnap;
        int acc, idx, w, total_w, base, seen;
        logic took;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.sa        = 5'd0;
        bus.func      = SH_SLL;
        bus.out_ready = 1'b1;

        // Pin the reference model to the hand-computed table.
        chk("model_sll_pin", model(32'h80000001, 4, 2'd0), 32'h00000010);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("model_pin_%0d", i), model(vec[i].a, int'(vec[i].s), vec[i].f), vec[i].exp);
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_z", bus.z, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Latency: accept, then out_valid appears on the third cycle after.
        bus.in_valid = 1'b1;
        bus.a        = 32'h80000001;
        bus.sa       = 5'd4;
        bus.func     = SH_SLL;
        @(negedge clk);
        chk("lat_accept", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c3_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_c3_z", bus.z, 32'h00000010);
        @(posedge clk);
        #1;
        drain();

        // Directed vectors, one at a time.
        for (int i = 0; i < 12; i++) begin
            send(vec[i], w);
            drain();
        end

        // Back-to-back: eight ops, eight results on consecutive cycles.
        total_w = 0;
        base    = out_cycles.size();
        for (int i = 0; i < 8; i++) begin
            send(vec[i], w);
            total_w += w;
        end
        drain();
        chk("b2b_in_ready_stalls", total_w, 32'd0);
        chk("b2b_count", out_cycles.size() - base, 32'd8);
        if (out_cycles.size() >= base + 8) begin
            chk("b2b_consecutive", out_cycles[base+7] - out_cycles[base], 32'd7);
        end

        // Stall: out_ready low for five cycles with requests always offered.
        base          = out_cycles.size();
        bus.out_ready = 1'b0;
        acc           = 0;
        idx           = 3;
        zsnap         = 32'd0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.a        = vec[idx].a;
            bus.sa       = vec[idx].s;
            bus.func     = shift_func_t'(vec[idx].f);
            @(negedge clk);
            took = bus.in_ready;
            if (took) acc++;
            if (c == 3) zsnap = bus.z;
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        chk("stall_accepted", acc, 32'd3);
        @(negedge clk);
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_z_frozen", bus.z, zsnap);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("stall_released_count", out_cycles.size() - base, 32'd3);

        // Reset with three ops in flight: nothing stale may emerge.
        for (int i = 8; i < 11; i++) begin
            send(vec[i], w);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst2_z", bus.z, 32'd0);
        chk("rst2_in_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rst2_no_stale", seen, 32'd0);
        @(posedge clk);
        #1;

        // Recovery after reset.
        base = out_cycles.size();
        send(vec[11], w);
        drain();
        chk("post_reset_count", out_cycles.size() - base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
